framebuffer_uart_dumper: RTL and testbench
==========================================

Name: framebuffer_uart_dumper

Overview:
Reads a finished frame back out of the VdRam frame buffer and streams it to a host over a UART 8N1 line. This is the reverse path of the ROM→processor→VdRam write flow: it lets the host capture and check the processed image. It uses a request/grant read port into VdRam, shared with VGA scanout through an external arbiter. Bytes are sent in order: header, raw pixels in raster order, optional checksum.

Parameters:
CLKS_PER_BIT, 434, CLOCK_50 cycles per UART bit (115200 baud); legal range ≥ 2.
MAX_PIXELS, 307200, largest legal frame_w*frame_h (640x480).

Ports:
CLOCK_50  input  1  system clock, 50 MHz; all logic on rising edge.
reset  input  1  asynchronous, active-high; clock CLOCK_50.
start  input  1  single-cycle request to dump the frame.
frame_w  input  10  frame width in pixels; sampled when start is accepted.
frame_h  input  10  frame height in pixels; sampled when start is accepted.
rd_req  output  1  read request to the VdRam arbiter.
rd_addr  output  19  VdRam read address; held stable while rd_req is high.
rd_gnt  input  1  arbiter grant; read occurs in any cycle with rd_req&&rd_gnt.
rd_data  input  8  VdRam q.
uart_tx  output  1  serial line; idles high.
busy  output  1  dump in progress.
done  output  1  one-cycle pulse when the final stop bit completes.
error  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values: uart_tx=1, rd_req=0, rd_addr=0, busy=0, done=0, error=0, FSM=IDLE, checksum=0.
- Reset is asynchronous. Asserting it mid-byte forces uart_tx high immediately, which truncates the frame. A later start always begins from the header.
- start is accepted only in IDLE; it is ignored while busy=1.
- On acceptance, latch W=frame_w and H=frame_h, and compute N=W*H as a 20-bit value.
  - If N>MAX_PIXELS: pulse error the next cycle, stay in IDLE, busy stays 0, no start bit is sent.
  - Otherwise busy goes to 1 the next cycle.
- Header is 6 bytes: 0xA5, 0x5A, {6'b0,W[9:8]}, W[7:0], {6'b0,H[9:8]}, H[7:0].
- FSM states: IDLE → HDR (send 6 bytes) → FETCH → WAIT → SEND → FETCH… → DONE → IDLE.
  - With CHECKSUM_EN, a CKSUM state runs before DONE.
  - If N==0: go HDR → DONE, with no reads.
- FETCH: hold rd_req=1 and rd_addr=pixel index p (0..N-1) until a cycle with rd_gnt=1. Drop rd_req the cycle after grant.
- WAIT: rd_data is valid on the second rising edge after the grant cycle (2-cycle RAM latency). Capture it into the tx byte register.
- SEND: transmit the captured byte, then increment p. If p==N-1 was just sent, go to DONE (or CKSUM); otherwise return to FETCH.
- The next fetch may overlap the current byte's transmission (prefetch of one byte allowed). No more than one byte is ever buffered.
- Pixel byte order is strictly p=0..N-1. There are no gaps in addressing; rd_addr wraps never, since N≤MAX_PIXELS<2^19.
- UART byte framing:
  - Each byte is start(0), d0..d7 (LSB first), stop(1).
  - Each bit lasts exactly CLKS_PER_BIT cycles, driven by a bit-timer counter reloaded per bit. A byte is therefore 10*CLKS_PER_BIT cycles.
  - Back-to-back bytes may follow with zero idle. If data is not ready (grant stall), uart_tx holds 1 between bytes.
- DONE: pulse done for 1 cycle, which is the cycle after the last stop bit ends. busy drops in the same cycle. Return to IDLE.
- A start arriving in the same cycle as done is ignored.

Optional Feature:
CHECKSUM_EN:
- Defined: a running XOR of all pixel bytes (header excluded, init 0x00 at start) is sent as one extra byte after the last pixel. The stream is 6+N+1 bytes.
- Undefined: no checksum logic; the stream is 6+N bytes.

Test Plan:
1. Assert reset then release, with idle inputs → uart_tx=1, busy=0, done=0, error=0, rd_req=0 for 100 cycles.
2. CLKS_PER_BIT=4, frame_w=2, frame_h=2, rd_gnt=1, RAM[i]=3i+1, pulse start → line decodes A5 5A 00 02 00 02 01 04 07 0A. With CHECKSUM_EN, one more byte 0x08 follows. Each byte is 40 cycles; one done pulse; rd_addr sequence 0,1,2,3.
3. As test 2, but rd_gnt held low for 100 cycles at the first FETCH → uart_tx stays 1 after the header for the stall, rd_addr holds 0, then the identical byte stream resumes with no loss.
4. frame_w=0, frame_h=5 → only the 6 header bytes A5 5A 00 00 00 05; rd_req never asserts; done pulses.
5. frame_w=641, frame_h=480 → error pulses 1 cycle; busy stays 0; uart_tx stays 1. A second start during a valid dump is ignored.
6. reset pulsed mid-pixel byte → uart_tx=1 within the same cycle and busy=0. A new start then produces the full header from 0xA5.

Source files
------------

// File: rtl/framebuffer_uart_dumper_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | framebuffer_uart_dumper_if                                       |
// | VdRam request/grant read port shared through the external arbiter|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface framebuffer_uart_dumper_if;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        rd_gnt;
    logic [7:0]  rd_data;

    modport master (output rd_req, rd_addr, input rd_gnt, rd_data);
    modport slave  (input rd_req, rd_addr, output rd_gnt, rd_data);
endinterface
`default_nettype wire

// File: rtl/framebuffer_uart_dumper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | framebuffer_uart_dumper                                          |
// | Streams header, raster pixels and (CHECKSUM_EN) an XOR byte      |
// | from VdRam over a UART 8N1 line.                                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module framebuffer_uart_dumper #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_PIXELS   = 307200
) (
    input  wire logic                  CLOCK_50,
    input  wire logic                  reset,
    input  wire logic                  start,
    input  wire logic [9:0]            frame_w,
    input  wire logic [9:0]            frame_h,
    framebuffer_uart_dumper_if.master  rd,
    output logic                       uart_tx,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int              c_TMR_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [19:0]     c_MAX_N    = 20'(MAX_PIXELS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_CKSUM = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [9:0]          r_w;
    logic [9:0]          r_h;
    logic [19:0]         r_n;
    logic [18:0]         r_pix;
    logic [2:0]          r_hdr_idx;
    logic [7:0]          r_tx_byte;
    logic                r_error;
`ifdef CHECKSUM_EN
    logic [7:0]          r_cksum;
`endif

    logic                r_tx_active;
    logic [8:0]          r_shift;
    logic [3:0]          r_bit_cnt;
    logic [c_TMR_W-1:0]  r_bit_tmr;
    logic                r_tx_line;

    logic [19:0]         w_n;
    logic                w_oversize;
    logic                w_accept;
    logic                w_tx_ready;
    logic                w_last_pix;
    logic [7:0]          w_hdr_byte;
    logic                w_load;
    logic [7:0]          w_load_byte;
    logic                w_done;

    assign w_n        = {10'd0, frame_w} * {10'd0, frame_h};
    assign w_oversize = (w_n > c_MAX_N);
    assign w_accept   = (r_state == S_IDLE) && start;
    // The shifter can take a new byte on the last cycle of a stop bit, so bytes can abut
    assign w_tx_ready = !r_tx_active || ((r_bit_tmr == '0) && (r_bit_cnt == 4'd9));
    assign w_last_pix = ({1'b0, r_pix} == (r_n - 20'd1));

    always_comb begin
        case (r_hdr_idx)
            3'd0:    w_hdr_byte = 8'hA5;
            3'd1:    w_hdr_byte = 8'h5A;
            3'd2:    w_hdr_byte = {6'b0, r_w[9:8]};
            3'd3:    w_hdr_byte = r_w[7:0];
            3'd4:    w_hdr_byte = {6'b0, r_h[9:8]};
            default: w_hdr_byte = r_h[7:0];
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_byte = r_tx_byte;
        w_done      = 1'b0;
        rd.rd_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !w_oversize) w_next = S_HDR;
            end
            S_HDR: begin
                if (w_tx_ready) begin
                    w_load      = 1'b1;
                    w_load_byte = w_hdr_byte;
                    if (r_hdr_idx == 3'd5) w_next = (r_n == 20'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                rd.rd_req = 1'b1;
                if (rd.rd_gnt) w_next = S_WAIT;
            end
            S_WAIT: w_next = S_SEND;
            S_SEND: begin
                if (w_tx_ready) begin
                    w_load      = 1'b1;
                    w_load_byte = r_tx_byte;
`ifdef CHECKSUM_EN
                    if (w_last_pix) w_next = S_CKSUM;
`else
                    if (w_last_pix) w_next = S_DONE;
`endif
                    else            w_next = S_FETCH;
                end
            end
            S_CKSUM: begin
`ifdef CHECKSUM_EN
                if (w_tx_ready) begin
                    w_load      = 1'b1;
                    w_load_byte = r_cksum;
                    w_next      = S_DONE;
                end
`else
                w_next = S_DONE;
`endif
            end
            S_DONE: begin
                // Wait until the final stop bit has fully elapsed
                if (!r_tx_active) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_w       <= '0;
            r_h       <= '0;
            r_n       <= '0;
            r_pix     <= '0;
            r_hdr_idx <= '0;
            r_tx_byte <= '0;
            r_error   <= 1'b0;
`ifdef CHECKSUM_EN
            r_cksum   <= '0;
`endif
        end else begin
            r_error <= w_accept && w_oversize;
            if (w_accept && !w_oversize) begin
                r_w       <= frame_w;
                r_h       <= frame_h;
                r_n       <= w_n;
                r_pix     <= '0;
                r_hdr_idx <= '0;
`ifdef CHECKSUM_EN
                r_cksum   <= '0;
`endif
            end
            if ((r_state == S_HDR) && w_load) r_hdr_idx <= r_hdr_idx + 3'd1;
            // rd_data is sampled on the second edge after the grant cycle
            if (r_state == S_WAIT) begin
                r_tx_byte <= rd.rd_data;
`ifdef CHECKSUM_EN
                r_cksum   <= r_cksum ^ rd.rd_data;
`endif
            end
            if ((r_state == S_SEND) && w_load && !w_last_pix) r_pix <= r_pix + 19'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_tx_active <= 1'b0;
            r_shift     <= '1;
            r_bit_cnt   <= '0;
            r_bit_tmr   <= '0;
            r_tx_line   <= 1'b1;
        end else if (w_load) begin
            r_tx_active <= 1'b1;
            r_shift     <= {1'b1, w_load_byte};
            r_bit_cnt   <= '0;
            r_bit_tmr   <= c_TMR_LAST;
            r_tx_line   <= 1'b0;
        end else if (r_tx_active) begin
            if (r_bit_tmr != '0) begin
                r_bit_tmr <= r_bit_tmr - 1'b1;
            end else if (r_bit_cnt == 4'd9) begin
                r_tx_active <= 1'b0;
                r_tx_line   <= 1'b1;
            end else begin
                r_tx_line <= r_shift[0];
                r_shift   <= {1'b1, r_shift[8:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_bit_tmr <= c_TMR_LAST;
            end
        end
    end

    assign rd.rd_addr = r_pix;
    assign uart_tx    = r_tx_line;
    assign busy       = (r_state != S_IDLE) && !w_done;
    assign done       = w_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_uart_dumper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_framebuffer_uart_dumper                                       |
// | Random frames against a queue-based stream model and UART decoder|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_framebuffer_uart_dumper;
    localparam int CPB = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic [9:0] frame_w  = '0;
    logic [9:0] frame_h  = '0;
    logic       uart_tx;
    logic       busy;
    logic       done;
    logic       error;

    framebuffer_uart_dumper_if rd_if();

    framebuffer_uart_dumper #(.CLKS_PER_BIT(CPB), .MAX_PIXELS(307200)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .frame_w  (frame_w),
        .frame_h  (frame_h),
        .rd       (rd_if),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [0:4095];
    logic [7:0] rx_q[$];
    int         addr_q[$];
    int         frame_err = 0;

    // RAM: data presented one edge after the grant, garbage otherwise
    always @(posedge CLOCK_50) begin
        if (rd_if.rd_req && rd_if.rd_gnt) begin
            rd_if.rd_data <= mem[rd_if.rd_addr[11:0]];
            addr_q.push_back(int'(rd_if.rd_addr));
        end else begin
            rd_if.rd_data <= 8'($urandom);
        end
    end

    // UART receiver: mid-bit sampling from the first low sample
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = '0;
    always @(negedge CLOCK_50) begin
        if (reset) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (uart_tx === 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 0;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if ((mon_cnt % CPB) == (CPB / 2 - 1)) begin
                if (mon_cnt / CPB == 0) begin
                    if (uart_tx !== 1'b0) frame_err <= frame_err + 1;
                end else if (mon_cnt / CPB <= 8) begin
                    mon_byte[mon_cnt / CPB - 1] <= uart_tx;
                end else begin
                    if (uart_tx !== 1'b1) frame_err <= frame_err + 1;
                    rx_q.push_back(mon_byte);
                    mon_active <= 1'b0;
                end
            end
        end
    end

    // gmode: 0 grant always, 1 random grant, 2 grant held low 100 cycles at first fetch
    task automatic run_dump(input int w, input int h, input int gmode, input bit pat,
                            input bit restart_mid, input bit start_at_done);
        logic [7:0]  exp_q[$];
        logic [7:0]  ck = 8'h00;
        logic [9:0]  wv = 10'(w);
        logic [9:0]  hv = 10'(h);
        int          n = w * h;
        int          cyc = 0;
        bit          got_done = 1'b0;
        int          stall_left = 100;
        int          stall_viol = 0;
        int          req_cycles = 0;
        int          unstable = 0;
        int          late_bad = 0;
        logic        prev_req = 1'b0;
        logic [18:0] prev_addr = '0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back({6'b0, wv[9:8]});
        exp_q.push_back(wv[7:0]);
        exp_q.push_back({6'b0, hv[9:8]});
        exp_q.push_back(hv[7:0]);
        for (int i = 0; i < n; i++) begin
            mem[i] = pat ? 8'(3 * i + 1) : 8'($urandom);
            exp_q.push_back(mem[i]);
            ck ^= mem[i];
        end
`ifdef CHECKSUM_EN
        if (n != 0) exp_q.push_back(ck);
`endif
        rx_q.delete();
        addr_q.delete();
        rd_if.rd_gnt = (gmode == 0);
        @(negedge CLOCK_50);
        frame_w = wv;
        frame_h = hv;
        start   = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_noerr", error, 0);
        while (cyc < 20000) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (rd_if.rd_req === 1'b1) begin
                req_cycles++;
                if (prev_req && rd_if.rd_addr !== prev_addr) unstable++;
            end
            prev_req  = rd_if.rd_req;
            prev_addr = rd_if.rd_addr;
            if (gmode == 1) begin
                rd_if.rd_gnt = 1'($urandom_range(0, 1));
            end else if (gmode == 2) begin
                if (rd_if.rd_req && stall_left > 0) begin
                    rd_if.rd_gnt = 1'b0;
                    if (rd_if.rd_addr !== 19'd0) stall_viol++;
                    if (stall_left < 50 && uart_tx !== 1'b1) stall_viol++;
                    stall_left--;
                end else begin
                    rd_if.rd_gnt = 1'b1;
                end
            end
            if (restart_mid && cyc == 200) begin
                frame_w = 10'd3;
                frame_h = 10'd3;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge CLOCK_50);
            cyc++;
        end
        check_eq("done_seen", got_done, 1);
        check_eq("done_busy_low", busy, 0);
        check_eq("done_line_idle", uart_tx, 1);
        if (start_at_done) begin
            frame_w = 10'd2;
            frame_h = 10'd2;
            start   = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            start = 1'b0;
            if (done !== 1'b0 || busy !== 1'b0 || uart_tx !== 1'b1) late_bad++;
        end
        check_eq("post_idle", late_bad, 0);
        check_eq("framing", frame_err, 0);
        check_eq("nbytes", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_eq($sformatf("byte%0d", i),
                     (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        check_eq("nreads", addr_q.size(), n);
        for (int i = 0; i < addr_q.size() && i < n; i++)
            check_eq($sformatf("addr%0d", i), addr_q[i], i);
        check_eq("addr_stable", unstable, 0);
        if (gmode == 2) check_eq("stall_hold", stall_viol, 0);
        if (n == 0) check_eq("no_req", req_cycles, 0);
    endtask

    task automatic oversize(input int w, input int h);
        int bad = 0;
        @(negedge CLOCK_50);
        frame_w = 10'(w);
        frame_h = 10'(h);
        start   = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check_eq("err_pulse", error, 1);
        check_eq("err_busy", busy, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK_50);
            if (error !== 1'b0 || busy !== 1'b0 || uart_tx !== 1'b1 || rd_if.rd_req !== 1'b0) bad++;
        end
        check_eq("err_quiet", bad, 0);
    endtask

    task automatic accept_max();
        @(negedge CLOCK_50);
        frame_w = 10'd640;
        frame_h = 10'd480;
        start   = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check_eq("max_busy", busy, 1);
        check_eq("max_noerr", error, 0);
        repeat (20) @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        check_eq("max_rst_busy", busy, 0);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic reset_mid();
        int cyc = 0;
        rd_if.rd_gnt = 1'b1;
        for (int i = 0; i < 9; i++) mem[i] = 8'($urandom);
        rx_q.delete();
        @(negedge CLOCK_50);
        frame_w = 10'd3;
        frame_h = 10'd3;
        start   = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        while (rx_q.size() < 7 && cyc < 5000) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        while (uart_tx !== 1'b0 && cyc < 5000) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        check_eq("rst_reached_px", rx_q.size(), 7);
        check_eq("rst_px0", (rx_q.size() > 6) ? {24'd0, rx_q[6]} : 32'hFFFF_FFFF, {24'd0, mem[0]});
        check_eq("rst_tx_low_before", uart_tx, 0);
        reset = 1'b1;
        #1;
        check_eq("rst_tx_async", uart_tx, 1);
        check_eq("rst_busy_async", busy, 0);
        check_eq("rst_req_async", rd_if.rd_req, 0);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check_eq("rst_tx_after", uart_tx, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int bad = 0;
        rd_if.rd_gnt = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_eq("rst_tx", uart_tx, 1);
        check_eq("rst_req", rd_if.rd_req, 0);
        check_eq("rst_addr", rd_if.rd_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", error, 0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
                error !== 1'b0 || rd_if.rd_req !== 1'b0) bad++;
        end
        check_eq("idle_100", bad, 0);

        run_dump(2, 2, 0, 1'b1, 1'b0, 1'b0);
        run_dump(2, 2, 2, 1'b1, 1'b0, 1'b0);
        run_dump(0, 5, 0, 1'b0, 1'b0, 1'b0);
        oversize(641, 480);
        oversize(1023, 1023);
        run_dump(3, 2, 1, 1'b0, 1'b1, 1'b0);
        accept_max();
        reset_mid();
        run_dump(2, 3, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            run_dump($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(0, 1),
                     1'b0, 1'b0, 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
